// File: rtl/uart_pkg.sv
// Shared definitions for the uart receive path: FSM encoding, oversampling constants, divider helper.
// Build option UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   // Clocks per oversample tick, truncated.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus receive-side result signals of uart_rx.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if #(parameter int DATA_BITS = 8);
   logic                 rx_in;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_error;
   logic                 parity_error;
   logic                 busy;

   modport master (input rx_in, output data_out, data_valid, frame_error, parity_error, busy);
   modport slave  (output rx_in, input data_out, data_valid, frame_error, parity_error, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
// i_clear holds the phase at zero so the first tick lands DIV clocks after release.
module uart_baud_tick #(
   parameter int DIV = 651
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   output logic o_tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(DIV - 1));
   assign o_tick = w_wrap & ~i_clear;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)              r_cnt <= '0;
      else if (i_clear || w_wrap) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with 16x oversampling, LSB-first reassembly, framing-error detect.
// Define UART_RX_PARITY_EN for an even parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8
) (
   input  logic      clock,
   input  logic      reset,
   uart_rx_if.master bus
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int BCW = $clog2(DATA_BITS + 1);

   logic [1:0]           r_sync;
   logic                 w_rx_s;
   logic                 w_tick;
   logic                 w_os_done;
   state_t               r_state,    w_state_nxt;
   logic [3:0]           r_tick_cnt, w_tick_cnt_nxt;
   logic [BCW-1:0]       r_bit_cnt,  w_bit_cnt_nxt;
   logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
   logic [DATA_BITS-1:0] r_data,     w_data_nxt;
   logic                 r_valid,    w_valid_nxt;
   logic                 r_ferr,     w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic                 r_par_bad,  w_par_bad_nxt;
   logic                 r_perr,     w_perr_nxt;
`endif

   // Flops reset high so the idle line never looks like a start edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], bus.rx_in};
   end
   assign w_rx_s = r_sync[1];

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clock   (clock),
      .reset   (reset),
      .i_clear (r_state == ST_IDLE),
      .o_tick  (w_tick)
   );

   assign w_os_done = w_tick && (r_tick_cnt == 4'(OVERSAMPLE - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad  <= 1'b0;
         r_perr     <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_ferr     <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bad  <= w_par_bad_nxt;
         r_perr     <= w_perr_nxt;
`endif
      end
   end

   // The 4-bit tick counter wraps 15->0 on its own, marking each bit period.
   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt + {3'b000, w_tick};
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_data_nxt     = r_data;
      w_valid_nxt    = 1'b0;
      w_ferr_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt  = r_par_bad;
      w_perr_nxt     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            if (!w_rx_s) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_tick && (r_tick_cnt == 4'(MID_SAMPLE - 1))) begin
               w_tick_cnt_nxt = '0;
               w_state_nxt    = w_rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_os_done) begin
               w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               if (r_bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_os_done) begin
               w_par_bad_nxt = w_rx_s ^ (^r_shift);
               w_state_nxt   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_os_done) begin
               if (w_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  w_perr_nxt  = r_par_bad;
`endif
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = ST_WAIT_HIGH;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (w_rx_s) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.data_out    = r_data;
   assign bus.data_valid  = r_valid;
   assign bus.frame_error = r_ferr;
   assign bus.busy        = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign bus.parity_error = r_perr;
`else
   assign bus.parity_error = 1'b0;
`endif
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the 8N1 serial link driven by the existing uart transmitter.
- Samples the serial line at 16x the baud rate and reassembles bytes LSB-first.
- Presents each good byte with a one-cycle valid strobe and flags framing errors.
- Sits beside uart on the same system clock (100 MHz in the standard bench).

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line; idles high; asynchronous to clock.
- data_out  output  DATA_BITS  last correctly received byte.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 when the optional feature is absent.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async): data_out=0, data_valid=0, frame_error=0, parity_error=0, busy=0, FSM=IDLE. Synchroniser flops reset to 1 so no false start is seen.
- rx_in passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Oversample tick:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; 651 at the defaults, giving a 10416-clock bit.
  - Tick is a one-clock pulse every DIV clocks.
  - Tick counter is held cleared while in IDLE, so sampling phase is aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_HIGH.
  - IDLE: rx_s=0 -> START; clear tick counter and sample counter.
  - START: after 8 ticks (mid start bit), sample rx_s. If 0 -> DATA. If 1 -> IDLE as a glitch/false start, with no output pulse.
  - DATA: every 16 ticks, shift rx_s into bit DATA_BITS-1 of the shift register (LSB-first). After DATA_BITS samples -> PARITY if the feature is enabled, else STOP.
  - PARITY: after 16 ticks, sample and compare against even parity of the shift register; the result is held for STOP.
  - STOP: after 16 ticks (mid stop bit), sample rx_s.
    - If 1: data_out <= shift register, data_valid=1 for exactly one clock, parity_error pulsed in the same cycle if a mismatch was recorded; -> IDLE.
    - If 0: frame_error=1 for one clock, data_out unchanged, data_valid stays 0; -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1 (break/stuck-low protection), then -> IDLE.
- Latency: data_valid asserts on the mid-stop sample, about 9.5 bit periods plus 2 sync clocks after the start falling edge.
- Back-to-back frames: returning to IDLE at mid-stop lets a start edge arriving at the stop bit's end be caught with no gap required.
- data_out holds its value until the next good frame.
- Reset during any state aborts the frame immediately. No pulse is produced, and reception resumes at the first falling edge after reset is released.
- busy=1 in all states except IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is start + DATA_BITS + even parity bit + stop; the PARITY state exists.
  - parity_error pulses alongside data_valid on mismatch; the data is still delivered.
  - frame_error takes priority: on a low stop bit neither data_valid nor parity_error pulses.
- Undefined: PARITY state and the parity logic are absent; parity_error is tied to 0.

Decomposition:
- Package uart_pkg:
  - FSM state encoding.
  - OVERSAMPLE=16 and MID_SAMPLE=8.
  - Function computing DIV from CLK_FREQ and BAUD.
- Sub-module uart_baud_tick:
  - Parameterised divider with a synchronous clear input and a tick output.
  - Shareable with the transmitter side.

Test Plan:
- Send 0xBA (8N1) with a 10416-clock bit after reset release -> data_out=0xBA, one data_valid pulse near mid stop bit, frame_error=0.
- rx_in low for 2000 clocks, then high -> no data_valid or frame_error pulse, busy returns to 0 within 8 ticks.
- Frame 0x55 with stop bit driven 0, line held low 3 bit periods, then 0xA5 -> frame_error pulse once, data_out stays at the prior value, then 0xA5 received normally.
- Back-to-back 0x00 then 0xFF with no idle gap -> two data_valid pulses, values 0x00 then 0xFF.
- Assert reset mid-DATA of 0x3C, release, then send 0x81 -> no pulse for 0x3C, data_out=0x81 after the second frame.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> data_out=0x07, data_valid and parity_error pulse in the same cycle.
